// File: rtl/usb_crc_pkg.sv
// Shared types and constants for the USB transmit-path CRC generator/appender.
// Holds the packet kinds, the controller states and the CRC polynomial defaults.
package usb_crc_pkg;

    typedef enum logic [1:0] {
        PKT_DATA   = 2'd0,
        PKT_TOKEN  = 2'd1,
        PKT_HSHAKE = 2'd2,
        PKT_RSVD   = 2'd3
    } pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_APPEND,
        ST_DRAIN
    } state_t;

    // SYNC as seen on the NRZ bit stream: seven zeros first, then a one.
    localparam logic [7:0] SYNC_PATTERN = 8'b0000_0001;

    localparam int CRC5_W  = 5;
    localparam int CRC16_W = 16;

    localparam logic [CRC5_W-1:0]  CRC5_POLY_DEF  = 5'b00101;
    localparam logic [CRC16_W-1:0] CRC16_POLY_DEF = 16'h8005;

    function automatic logic has_crc(input pkt_t t);
        return (t == PKT_DATA) || (t == PKT_TOKEN);
    endfunction

endpackage

// File: rtl/usb_crc_gen_bit_fifo.sv
// Single-bit-wide FIFO with occupancy count; a push into a full FIFO succeeds
// only when a pop happens in the same cycle, otherwise the bit is dropped.
module bit_fifo #(
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic                   re,
    input  logic                   bit_in,
    output logic                   bit_out,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_rd   = re && !empty;
    assign do_wr   = we && (!full || do_rd);
    assign bit_out = mem[rd_ptr];

    // NOTE: storage carries no reset; validity of each bit is defined by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= bit_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking, so each register sees pre-edge values whatever the statement order.
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/usb_crc_gen.sv
// Serial CRC5/CRC16 generator and appender: buffers the packet in a bit FIFO,
// appends the complemented CRC after the payload and streams out under pause.
module usb_crc_gen
    import usb_crc_pkg::*;
#(
    parameter int                   DEPTH      = 32,
    parameter int                   PRELOAD    = 8,
    parameter int                   SKIP       = 16,
    parameter logic [CRC5_W-1:0]    CRC5_POLY  = CRC5_POLY_DEF,
    parameter logic [CRC16_W-1:0]   CRC16_POLY = CRC16_POLY_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_in,
    input  logic       start,
    input  logic       endr,
    input  logic [1:0] pkt_type,
    input  logic       pause,
    output logic       s_out,
    output logic       out_valid,
    output logic       start_b,
    output logic       endr_b,
    output logic       busy,
    output logic       ovf
);

    localparam int            AW          = $clog2(DEPTH);
    localparam int            CW          = $clog2(SKIP + 1);
    localparam logic [AW:0]   PRELOAD_CNT = (AW+1)'(PRELOAD);
    localparam logic [AW:0]   CNT_ONE     = (AW+1)'(1);
    localparam logic [CW-1:0] SKIP_CNT    = CW'(SKIP);

    state_t               state_q, state_d;
    pkt_t                 type_q, start_type;
    logic [CW-1:0]        skip_cnt_q;
    logic [CRC5_W-1:0]    crc5_q;
    logic [CRC16_W-1:0]   crc16_q;
    logic [3:0]           app_idx_q;
    logic [2:0]           app_idx5;
    logic                 app_last, app_bit;
    logic                 out_en, out_en_q, first_q, ovf_q, accept;
    logic                 we, re, bit_in, bit_out, full, empty;
    logic [AW:0]          count;

    bit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .re      (re),
        .bit_in  (bit_in),
        .bit_out (bit_out),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign start_type = pkt_t'(pkt_type);
    assign accept     = start && (state_q == ST_IDLE);

    // Append walks the frozen CRC MSB first; for CRC16 index 15-k is simply ~k.
    assign app_idx5 = app_idx_q[2:0];
    assign app_last = (type_q == PKT_TOKEN) ? (app_idx_q == 4'(CRC5_W - 1))
                                            : (app_idx_q == 4'(CRC16_W - 1));
    assign app_bit  = (type_q == PKT_TOKEN) ? ~crc5_q[3'(CRC5_W - 1) - app_idx5]
                                            : ~crc16_q[~app_idx_q];

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d = state_q;
        we      = 1'b0;
        bit_in  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    we     = 1'b1;
                    bit_in = s_in;
                    if (!endr)                 state_d = ST_RECV;
                    else if (has_crc(start_type)) state_d = ST_APPEND;
                    else                       state_d = ST_DRAIN;
                end
            end
            ST_RECV: begin
                we     = 1'b1;
                bit_in = s_in;
                if (endr) state_d = has_crc(type_q) ? ST_APPEND : ST_DRAIN;
            end
            ST_APPEND: begin
                we     = 1'b1;
                bit_in = app_bit;
                if (app_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (re && (count == CNT_ONE)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_en    = out_en_q || (count >= PRELOAD_CNT) ||
                       (state_q == ST_APPEND) || (state_q == ST_DRAIN);
    assign out_valid = out_en && !empty;
    assign re        = out_valid && !pause;
    assign s_out     = out_valid && bit_out;
    assign start_b   = out_valid && first_q;
    // Nothing is pushed in DRAIN, so a single remaining bit is the packet's last one.
    assign endr_b    = out_valid && (state_q == ST_DRAIN) && (count == CNT_ONE);
    assign busy      = (state_q != ST_IDLE);
    assign ovf       = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            type_q     <= PKT_DATA;
            skip_cnt_q <= '0;
            crc5_q     <= '1;
            crc16_q    <= '1;
            app_idx_q  <= '0;
            out_en_q   <= 1'b0;
            first_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_en_q <= (state_d != ST_IDLE) && out_en;
            if (re) first_q <= 1'b0;
            if (accept) begin
                type_q     <= start_type;
                skip_cnt_q <= CW'(1);
                crc5_q     <= '1;
                crc16_q    <= '1;
                app_idx_q  <= '0;
                first_q    <= 1'b1;
                ovf_q      <= (start_type == PKT_RSVD);
            end else begin
                if (start || (we && full && !re)) ovf_q <= 1'b1;
                if (state_q == ST_RECV) begin
                    if (skip_cnt_q == SKIP_CNT) begin
                        crc5_q  <= {crc5_q[CRC5_W-2:0], 1'b0} ^
                                   ((crc5_q[CRC5_W-1] ^ s_in) ? CRC5_POLY : '0);
                        crc16_q <= {crc16_q[CRC16_W-2:0], 1'b0} ^
                                   ((crc16_q[CRC16_W-1] ^ s_in) ? CRC16_POLY : '0);
                    end else begin
                        skip_cnt_q <= skip_cnt_q + CW'(1);
                    end
                end
                if (state_q == ST_APPEND) app_idx_q <= app_idx_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_usb_crc_gen.sv
// Directed bench for usb_crc_gen: known token/data/handshake packets with
// hand-computed CRC tails, pause patterns, overflow, abort by reset.
module tb_usb_crc_gen;
    import usb_crc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_in = 1'b0, start = 1'b0, endr = 1'b0, pause = 1'b0;
    logic [1:0] pkt_type = 2'd0;
    logic       s_out, out_valid, start_b, endr_b, busy, ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int hold_bad = 0;
    logic busy_at1 = 1'b0;
    logic [2:0] pend = 3'b000;
    logic pend_v = 1'b0;

    logic tx[$];
    logic exp_bits[$];
    logic rx_bits[$];
    logic rx_sb[$];
    logic rx_eb[$];
    int   rx_cyc[$];

    usb_crc_gen #(
        .DEPTH(32), .PRELOAD(8), .SKIP(16),
        .CRC5_POLY(5'b00101), .CRC16_POLY(16'h8005)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_in(s_in), .start(start), .endr(endr),
        .pkt_type(pkt_type), .pause(pause), .s_out(s_out), .out_valid(out_valid),
        .start_b(start_b), .endr_b(endr_b), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] pack(input logic q[$]);
        logic [127:0] v = '0;
        foreach (q[i]) if (i < 128) v[i] = q[i];
        return v;
    endfunction

    // Drive one cycle of inputs at the falling edge, then sample what the next rising edge consumes.
    task automatic step(input logic b, input logic st, input logic en,
                        input logic [1:0] ty, input logic pa);
        @(negedge clk);
        cyc++;
        s_in = b; start = st; endr = en; pkt_type = ty; pause = pa;
        #1;
        if (pend_v) begin
            if ({s_out, start_b, endr_b} !== pend) hold_bad++;
            pend_v = 1'b0;
        end
        if (out_valid && pause) begin
            pend = {s_out, start_b, endr_b};
            pend_v = 1'b1;
        end else if (out_valid) begin
            rx_bits.push_back(s_out);
            rx_sb.push_back(start_b);
            rx_eb.push_back(endr_b);
            rx_cyc.push_back(cyc);
        end
    endtask

    function automatic logic pz(input int mod, input int i, input int plo, input int phi);
        return ((mod != 0) && ((cyc % mod) == mod - 1)) || ((i >= plo) && (i <= phi));
    endfunction

    // pkt_type is only driven on the start cycle so a design that uses it later is caught.
    task automatic send_pkt(input logic [1:0] ty, input int mod, input int plo,
                            input int phi, input int dup);
        rx_bits.delete(); rx_sb.delete(); rx_eb.delete(); rx_cyc.delete();
        pend_v = 1'b0;
        start_cyc = cyc + 1;
        for (int i = 0; i < tx.size(); i++) begin
            step(tx[i], (i == 0) || (i == dup), i == tx.size() - 1,
                 (i == 0) ? ty : 2'd0, pz(mod, i, plo, phi));
            if (i == 1) busy_at1 = busy;
        end
    endtask

    task automatic drain(input string tag, input int mod);
        int n = 0;
        do begin
            step(1'b0, 1'b0, 1'b0, 2'd0, pz(mod, 0, 1, 0));
            n++;
        end while (busy && n < 300);
        check({tag, "_drained"}, busy, 1'b0);
    endtask

    task automatic check_pkt(input string tag);
        check({tag, "_len"}, rx_bits.size(), exp_bits.size());
        check({tag, "_bits"}, pack(rx_bits), pack(exp_bits));
        check({tag, "_start_b"}, pack(rx_sb), 128'd1);
        check({tag, "_endr_b"}, pack(rx_eb), 128'd1 << (exp_bits.size() - 1));
    endtask

    task automatic push_sync();
        for (int i = 7; i >= 0; i--) tx.push_back(SYNC_PATTERN[i]);
    endtask

    task automatic push_lsb(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) tx.push_back(v[i]);
    endtask

    task automatic exp_msb(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_bits.push_back(v[i]);
    endtask

    task automatic build_token();
        tx.delete();
        push_sync(); push_lsb(64'hE1, 8); push_lsb(64'h15, 7); push_lsb(64'hE, 4);
        exp_bits = tx;
        exp_msb(16'b10111, 5);
    endtask

    // Payload FF FF 00 00 00 00 00 40: sixteen ones clear the CRC, the 0x40 tail leaves 0x800F.
    task automatic build_data8();
        tx.delete();
        push_sync(); push_lsb(64'hC3, 8); push_lsb(64'h4000_0000_0000_FFFF, 64);
        exp_bits = tx;
        exp_msb(16'h7FF0, 16);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", {s_out, out_valid, start_b, endr_b, busy, ovf}, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_outputs", {s_out, out_valid, start_b, endr_b, busy, ovf}, 6'b0);

        // TOKEN OUT addr 0x15 endp 0xE
        build_token();
        send_pkt(PKT_TOKEN, 0, 1, 0, -1);
        check("token_busy", busy_at1, 1'b1);
        drain("token", 0);
        check_pkt("token");
        check("token_latency", rx_cyc[0] - start_cyc, 8);
        check("token_ovf", ovf, 1'b0);

        // Zero-length DATA0: CRC of nothing is ~FFFF = 0
        tx.delete();
        push_sync(); push_lsb(64'hC3, 8);
        exp_bits = tx;
        exp_msb(16'h0000, 16);
        send_pkt(PKT_DATA, 0, 1, 0, -1);
        drain("data0z", 0);
        check_pkt("data0z");

        // Handshake ACK: no CRC
        tx.delete();
        push_sync(); push_lsb(64'hD2, 8);
        exp_bits = tx;
        send_pkt(PKT_HSHAKE, 0, 1, 0, -1);
        drain("ack", 0);
        check_pkt("ack");

        // DATA 8-byte payload, no pause
        build_data8();
        send_pkt(PKT_DATA, 0, 1, 0, -1);
        drain("data8", 0);
        check_pkt("data8");

        // Same packet with pause one cycle in six
        build_data8();
        hold_bad = 0;
        send_pkt(PKT_DATA, 6, 1, 0, -1);
        drain("data8p", 6);
        check_pkt("data8p");
        check("data8p_ovf", ovf, 1'b0);
        check("data8p_hold", hold_bad, 0);

        // Pause held 40 cycles mid-packet overflows the FIFO
        build_data8();
        send_pkt(PKT_DATA, 0, 20, 59, -1);
        check("ovf_set", ovf, 1'b1);
        drain("ovfpkt", 0);
        check("ovf_sticky", ovf, 1'b1);

        // Next accepted start clears ovf and the FIFO is clean again
        tx.delete();
        push_sync(); push_lsb(64'hD2, 8);
        exp_bits = tx;
        send_pkt(PKT_HSHAKE, 0, 1, 0, -1);
        drain("ack2", 0);
        check_pkt("ack2");
        check("ovf_cleared", ovf, 1'b0);

        // Start while busy is ignored but flags ovf
        build_token();
        send_pkt(PKT_TOKEN, 0, 1, 0, 10);
        drain("dupstart", 0);
        check_pkt("dupstart");
        check("dupstart_ovf", ovf, 1'b1);

        // Reserved type, start and endr together: one bit, no CRC, ovf set
        tx.delete();
        tx.push_back(1'b1);
        exp_bits = tx;
        send_pkt(PKT_RSVD, 0, 1, 0, -1);
        drain("rsvd1", 0);
        check_pkt("rsvd1");
        check("rsvd1_ovf", ovf, 1'b1);

        // Reset in the middle of APPEND, then a fresh TOKEN
        build_token();
        send_pkt(PKT_TOKEN, 0, 1, 0, -1);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("pre_abort_valid", out_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {s_out, out_valid, start_b, endr_b, busy, ovf}, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        build_token();
        send_pkt(PKT_TOKEN, 0, 1, 0, -1);
        drain("token_after_rst", 0);
        check_pkt("token_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
